// File: rtl/mul_sequencer_if.sv
// EX-side request/response and multiplier start/fin handshake bundle for mul_sequencer.
interface mul_sequencer_if;
  localparam int unsigned XLEN = 32;
  localparam int unsigned PW   = 64;
  localparam int unsigned OPW  = 3;

  // EX side
  logic            ex_valid;
  logic [OPW-1:0]  funct3;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic            flush;
  logic            stall;
  logic [XLEN-1:0] result;
  logic            result_valid;

  // multiplier side
  logic            mul_start;
  logic [OPW-1:0]  mul_op;
  logic [XLEN-1:0] mul_a;
  logic [XLEN-1:0] mul_b;
  logic            mul_fin;
  logic [PW-1:0]   mul_product;

  // driver of EX requests and of the multiplier responses
  modport master (
    output ex_valid, funct3, rs1_data, rs2_data, flush, mul_fin, mul_product,
    input  stall, result, result_valid, mul_start, mul_op, mul_a, mul_b
  );

  // the sequencer itself
  modport slave (
    input  ex_valid, funct3, rs1_data, rs2_data, flush, mul_fin, mul_product,
    output stall, result, result_valid, mul_start, mul_op, mul_a, mul_b
  );
endinterface

// File: rtl/mul_sequencer.sv
// Sequences RV32M multiplies between EX and the iterative multiplier, with a one-entry
// product cache so MUL/MULH pairs on identical operands need only one multiply.
module mul_sequencer (
  input  logic            clk,
  input  logic            rst,
  mul_sequencer_if.slave  bus
);
  localparam int unsigned XLEN = 32;
  localparam int unsigned PW   = 64;
  localparam int unsigned OPW  = 3;
  localparam logic [OPW-1:0] F3_MUL = OPW'(0);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_DONE  = 3'd3,
    S_DRAIN = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic            cache_valid_q, cache_valid_d;
  logic [XLEN-1:0] c_a_q, c_a_d;
  logic [XLEN-1:0] c_b_q, c_b_d;
  logic [OPW-1:0]  c_op_q, c_op_d;
  logic [PW-1:0]   c_prod_q, c_prod_d;
  logic [XLEN-1:0] mul_a_q, mul_a_d;
  logic [XLEN-1:0] mul_b_q, mul_b_d;
  logic [OPW-1:0]  mul_op_q, mul_op_d;
  logic            mul_start_q, mul_start_d;
  logic [XLEN-1:0] result_q, result_d;

  logic            req_c;
  logic            hit_c;
  logic            stall_c;
  logic            result_valid_c;
  logic            sel_lo_c;
  logic [XLEN-1:0] half_c;
  logic [XLEN-1:0] result_c;

  // Request qualification and cache lookup; the low word is sign-independent so MUL hits any op
  always_comb begin
    req_c = bus.ex_valid & ~bus.funct3[2] & ~bus.flush;
    hit_c = cache_valid_q && (bus.rs1_data == c_a_q) && (bus.rs2_data == c_b_q) &&
            ((bus.funct3 == F3_MUL) || (bus.funct3 == c_op_q));
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cache_valid_q <= 1'b0;
      c_a_q         <= '0;
      c_b_q         <= '0;
      c_op_q        <= '0;
      c_prod_q      <= '0;
      mul_a_q       <= '0;
      mul_b_q       <= '0;
      mul_op_q      <= '0;
      mul_start_q   <= 1'b0;
      result_q      <= '0;
    end else begin
      state_q       <= state_d;
      cache_valid_q <= cache_valid_d;
      c_a_q         <= c_a_d;
      c_b_q         <= c_b_d;
      c_op_q        <= c_op_d;
      c_prod_q      <= c_prod_d;
      mul_a_q       <= mul_a_d;
      mul_b_q       <= mul_b_d;
      mul_op_q      <= mul_op_d;
      mul_start_q   <= mul_start_d;
      result_q      <= result_d;
    end
  end

  // Next-state decision
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (req_c && !hit_c) state_d = S_ISSUE;
      S_ISSUE: state_d = bus.flush ? S_DRAIN : S_WAIT;
      S_WAIT: begin
        if (bus.mul_fin)    state_d = bus.flush ? S_IDLE : S_DONE;
        else if (bus.flush) state_d = S_DRAIN;
      end
      S_DONE:  state_d = S_IDLE;
      S_DRAIN: if (bus.mul_fin) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs, operand latching, cache fill and result selection
  always_comb begin
    cache_valid_d  = cache_valid_q;
    c_a_d          = c_a_q;
    c_b_d          = c_b_q;
    c_op_d         = c_op_q;
    c_prod_d       = c_prod_q;
    mul_a_d        = mul_a_q;
    mul_b_d        = mul_b_q;
    mul_op_d       = mul_op_q;
    stall_c        = 1'b0;
    result_valid_c = 1'b0;
    sel_lo_c       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req_c) begin
          if (hit_c) begin
            result_valid_c = 1'b1;
            sel_lo_c       = (bus.funct3 == F3_MUL);
          end else begin
            stall_c  = 1'b1;
            mul_a_d  = bus.rs1_data;
            mul_b_d  = bus.rs2_data;
            mul_op_d = bus.funct3;
          end
        end
      end
      S_ISSUE: stall_c = 1'b1;
      S_WAIT: begin
        stall_c = 1'b1;
        // the cache fills even when this instruction is being flushed
        if (bus.mul_fin) begin
          cache_valid_d = 1'b1;
          c_a_d         = mul_a_q;
          c_b_d         = mul_b_q;
          c_op_d        = mul_op_q;
          c_prod_d      = bus.mul_product;
        end
      end
      S_DONE: begin
        result_valid_c = ~bus.flush;
        sel_lo_c       = (mul_op_q == F3_MUL);
      end
      S_DRAIN: stall_c = req_c;
      default: stall_c = 1'b0;
    endcase

    mul_start_d = (state_d == S_ISSUE);
    half_c      = sel_lo_c ? c_prod_q[XLEN-1:0] : c_prod_q[PW-1:XLEN];
    result_c    = result_valid_c ? half_c : result_q;
    result_d    = result_c;
  end

  assign bus.stall        = stall_c;
  assign bus.result_valid = result_valid_c;
  assign bus.result       = result_c;
  assign bus.mul_start    = mul_start_q;
  assign bus.mul_op       = mul_op_q;
  assign bus.mul_a        = mul_a_q;
  assign bus.mul_b        = mul_b_q;
endmodule

// File: tb/tb_mul_sequencer.sv
// Scoreboard bench for mul_sequencer with a delay-programmable multiplier model.
module tb_mul_sequencer;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mul_sequencer_if bus ();
  mul_sequencer u_dut (.clk(clk), .rst(rst), .bus(bus));

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int start_cnt = 0;
  int start_cyc = 0;
  int model_delay = 4;
  logic [63:0] model_product = '0;
  bit model_busy = 1'b0;
  logic [31:0] exp_q [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Start pulse counter
  initial forever begin
    @(negedge clk);
    if (bus.mul_start === 1'b1) begin
      start_cnt++;
      start_cyc = cyc;
    end
  end

  // Multiplier model: mul_fin model_delay cycles after the start cycle
  initial begin
    bus.mul_fin     = 1'b0;
    bus.mul_product = '0;
    forever begin
      @(negedge clk);
      if (bus.mul_start === 1'b1) begin
        model_busy = 1'b1;
        repeat (model_delay) @(posedge clk);
        #1;
        bus.mul_fin     = 1'b1;
        bus.mul_product = model_product;
        @(posedge clk);
        #1;
        bus.mul_fin     = 1'b0;
        bus.mul_product = '0;
        model_busy      = 1'b0;
      end
    end
  end

  // Scoreboard monitor
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      #1;
      if (bus.result_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result_valid", 64'(bus.result_valid), 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("result", 64'(bus.result), 64'(e));
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic do_req(input string name, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input bit exp_hit, input logic [63:0] prod,
                        input int dly, input logic [31:0] exp_res);
    int s0, t0, stalls, lat;
    bit got;
    model_product = prod;
    model_delay   = dly;
    @(posedge clk); #1;
    bus.ex_valid = 1'b1;
    bus.funct3   = f3;
    bus.rs1_data = a;
    bus.rs2_data = b;
    exp_q.push_back(exp_res);
    s0 = start_cnt; t0 = cyc; stalls = 0; lat = 0; got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk); #1;
      if (bus.result_valid === 1'b1) begin
        got = 1'b1;
        check({name, "_stall_at_result"}, 64'(bus.stall), 64'd0);
      end else begin
        lat++;
        if (bus.stall === 1'b1) stalls++;
      end
    end
    check({name, "_completed"}, 64'(got), 64'd1);
    check({name, "_latency"}, 64'(lat), exp_hit ? 64'd0 : 64'(dly + 2));
    check({name, "_stall_cycles"}, 64'(stalls), exp_hit ? 64'd0 : 64'(dly + 2));
    check({name, "_starts"}, 64'(start_cnt - s0), exp_hit ? 64'd0 : 64'd1);
    if (!exp_hit) check({name, "_start_cycle"}, 64'(start_cyc - t0), 64'd1);
    @(posedge clk); #1;
    bus.ex_valid = 1'b0;
  endtask

  task automatic wait_model_idle(input string name);
    for (int i = 0; i < 200 && model_busy; i++) @(posedge clk);
    check({name, "_model_idle"}, 64'(model_busy), 64'd0);
    repeat (2) @(posedge clk);
  endtask

  initial begin
    int s0;
    rst = 1'b1;
    bus.ex_valid = 1'b0;
    bus.funct3   = '0;
    bus.rs1_data = '0;
    bus.rs2_data = '0;
    bus.flush    = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // reset values
    @(negedge clk); #1;
    check("rst_stall", 64'(bus.stall), 64'd0);
    check("rst_result_valid", 64'(bus.result_valid), 64'd0);
    check("rst_mul_start", 64'(bus.mul_start), 64'd0);
    check("rst_result", 64'(bus.result), 64'd0);
    check("rst_mul_a", 64'(bus.mul_a), 64'd0);
    check("rst_mul_b", 64'(bus.mul_b), 64'd0);
    check("rst_mul_op", 64'(bus.mul_op), 64'd0);

    // basic MUL, 34-cycle multiplier
    do_req("mul_7x6", 3'b000, 32'd7, 32'd6, 1'b0, 64'd42, 34, 32'h0000_002A);
    @(negedge clk); #1;
    check("result_hold", 64'(bus.result), 64'h2A);
    check("mul_op_after", 64'(bus.mul_op), 64'd0);

    // MULHU then MUL on same operands: second hits the cache
    do_req("mulhu_ff", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0,
           64'hFFFF_FFFE_0000_0001, 5, 32'hFFFF_FFFE);
    do_req("mul_ff_hit", 3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1,
           64'd0, 5, 32'h0000_0001);

    // MULH then MULHU on same operands: different op misses
    do_req("mulh_8000", 3'b001, 32'h8000_0000, 32'd2, 1'b0,
           64'hFFFF_FFFF_0000_0000, 3, 32'hFFFF_FFFF);
    do_req("mulhu_8000", 3'b011, 32'h8000_0000, 32'd2, 1'b0,
           64'h0000_0001_0000_0000, 3, 32'h0000_0001);

    // divide op is ignored
    @(posedge clk); #1;
    bus.ex_valid = 1'b1; bus.funct3 = 3'b100; bus.rs1_data = 32'd7; bus.rs2_data = 32'd6;
    s0 = start_cnt;
    @(negedge clk); #1;
    check("div_stall", 64'(bus.stall), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    check("div_no_start", 64'(start_cnt - s0), 64'd0);
    bus.ex_valid = 1'b0;

    // flush in WAIT: drain, no result, cache untouched
    model_product = 64'd15; model_delay = 10;
    @(posedge clk); #1;
    bus.ex_valid = 1'b1; bus.funct3 = 3'b000; bus.rs1_data = 32'd3; bus.rs2_data = 32'd5;
    s0 = start_cnt;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.flush = 1'b1; bus.ex_valid = 1'b0;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    @(negedge clk); #1;
    check("drain_stall_no_req", 64'(bus.stall), 64'd0);
    wait_model_idle("flush");
    check("flush_starts", 64'(start_cnt - s0), 64'd1);
    do_req("mul_3x5_after_flush", 3'b000, 32'd3, 32'd5, 1'b0, 64'd15, 5, 32'd15);

    // reset during WAIT
    do_req("mul_11x13", 3'b000, 32'd11, 32'd13, 1'b0, 64'd143, 3, 32'd143);
    model_product = 64'd143; model_delay = 20;
    @(posedge clk); #1;
    bus.ex_valid = 1'b1; bus.funct3 = 3'b011; bus.rs1_data = 32'd11; bus.rs2_data = 32'd13;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1; bus.ex_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk); #1;
    check("midrst_stall", 64'(bus.stall), 64'd0);
    check("midrst_mul_start", 64'(bus.mul_start), 64'd0);
    check("midrst_mul_a", 64'(bus.mul_a), 64'd0);
    check("midrst_mul_b", 64'(bus.mul_b), 64'd0);
    check("midrst_mul_op", 64'(bus.mul_op), 64'd0);
    check("midrst_result", 64'(bus.result), 64'd0);
    wait_model_idle("midrst");
    do_req("mul_11x13_after_rst", 3'b000, 32'd11, 32'd13, 1'b0, 64'd143, 3, 32'd143);

    repeat (5) @(posedge clk);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
